// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding and
// the number of bytes that make up a header or a body word.
package program_loader_pkg;

    typedef enum logic [1:0] {
        ST_HEADER,
        ST_BODY,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    // Header and body words are both four big-endian bytes.
    localparam int HEADER_BYTES = 4;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The master modport is the loader's view, the slave modport is its environment.
interface program_loader_if #(
    parameter int ADDR_WIDTH = 17
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rearm;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [ADDR_WIDTH-2:0] words_written;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        input  rx_valid, rx_data, rearm,
        output mem_we, mem_addr, mem_wdata, words_written, busy, done, error
    );

    modport slave (
        output rx_valid, rx_data, rearm,
        input  mem_we, mem_addr, mem_wdata, words_written, busy, done, error
    );
endinterface

// File: rtl/program_loader_byte_assembler.sv
// Collects bytes into a big-endian 32-bit word; the completed word and its
// valid flag are presented combinationally alongside the fourth byte.
module byte_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    input  logic        i_clear,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    // Only the three most recent bytes need storage; the fourth arrives live.
    logic [23:0] r_shift;
    logic [1:0]  r_byte_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (i_clear) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (i_valid) begin
            r_shift    <= {r_shift[15:0], i_byte};
            r_byte_cnt <= r_byte_cnt + 2'd1;
        end
    end

    assign o_word       = {r_shift, i_byte};
    assign o_word_valid = i_valid && !i_clear && (r_byte_cnt == 2'(HEADER_BYTES - 1));

endmodule

// File: rtl/program_loader.sv
// Writes a length-prefixed big-endian byte stream into instruction memory as
// 32-bit words and holds the core off (busy) until the image is complete.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int MAX_WORDS  = 2 ** (ADDR_WIDTH - 2)
) (
    input logic             clk,
    input logic             reset,
    program_loader_if.master bus
);

    localparam logic [31:0]           MAX_WORDS_W = 32'(MAX_WORDS);
    localparam logic [ADDR_WIDTH-2:0] WW_ONE      = 1;

    loader_state_t         r_state;
    loader_state_t         w_next_state;
    logic [31:0]           r_n;
    logic [ADDR_WIDTH-2:0] r_words_written;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;

    logic        w_active;
    logic        w_rearm;
    logic        w_asm_valid;
    logic        w_word_valid;
    logic [31:0] w_word;
    logic        w_write;
    logic        w_latch_n;
    logic        w_last_word;

    // Bytes are ignored outside HEADER/BODY, and rearm only acts in DONE/ERROR.
    assign w_active    = (r_state == ST_HEADER) || (r_state == ST_BODY);
    assign w_rearm     = bus.rearm && !w_active;
    assign w_asm_valid = bus.rx_valid && w_active;
    assign w_last_word = ((32'(r_words_written) + 32'd1) == r_n);

    byte_assembler u_assembler (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (w_asm_valid),
        .i_byte       (bus.rx_data),
        .i_clear      (w_rearm),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_HEADER;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The header length is judged at full 32-bit width so oversize counts never truncate.
    always_comb begin
        w_next_state = r_state;
        w_write      = 1'b0;
        w_latch_n    = 1'b0;
        case (r_state)
            ST_HEADER: begin
                if (w_word_valid) begin
                    w_latch_n = 1'b1;
                    if (w_word == 32'd0) begin
                        w_next_state = ST_DONE;
                    end else if (w_word > MAX_WORDS_W) begin
                        w_next_state = ST_ERROR;
                    end else begin
                        w_next_state = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (w_word_valid) begin
                    w_write = 1'b1;
                    if (w_last_word) begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_DONE, ST_ERROR: begin
                if (bus.rearm) begin
                    w_next_state = ST_HEADER;
                end
            end
            default: begin
                w_next_state = ST_HEADER;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n             <= '0;
            r_words_written <= '0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
        end else begin
            r_mem_we <= w_write;
            if (w_latch_n) begin
                r_n <= w_word;
            end
            if (w_write) begin
                r_mem_addr      <= {r_words_written[ADDR_WIDTH-3:0], 2'b00};
                r_mem_wdata     <= w_word;
                r_words_written <= r_words_written + WW_ONE;
            end
            if (w_rearm) begin
                r_n             <= '0;
                r_words_written <= '0;
            end
        end
    end

    assign bus.mem_we        = r_mem_we;
    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_wdata     = r_mem_wdata;
    assign bus.words_written = r_words_written;
    assign bus.busy          = w_active;
    assign bus.done          = (r_state == ST_DONE);
    assign bus.error         = (r_state == ST_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: the expected outputs are derived from
// the history of accepted bytes, plus literal checks on the directed scenarios.
module tb_program_loader;

    localparam int AW   = 17;
    localparam int MAXW = 2 ** (AW - 2);

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic          doneAtStrobe;
    } wrRec_t;

    logic clk = 1'b0;
    logic reset;

    program_loader_if #(.ADDR_WIDTH(AW)) bus ();

    program_loader #(
        .ADDR_WIDTH (AW),
        .MAX_WORDS  (MAXW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;
    int cycle   = 0;

    logic [7:0] stim[$];
    wrRec_t     writeLog[$];

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Reference model: every output follows from the bytes accepted since the last arm.
    logic [7:0]    acc[$];
    logic          expWe;
    logic [AW-1:0] expAddr;
    logic [31:0]   expData;

    function automatic logic [31:0] headerN();
        return {acc[0], acc[1], acc[2], acc[3]};
    endfunction

    function automatic bit isError();
        return (acc.size() >= 4) && (headerN() > 32'(MAXW));
    endfunction

    function automatic int wordsDone();
        return (acc.size() >= 4 && !isError()) ? (acc.size() - 4) / 4 : 0;
    endfunction

    function automatic bit isDone();
        return (acc.size() >= 4) && !isError() && (wordsDone() == int'(headerN()));
    endfunction

    always @(posedge clk or posedge reset) begin
        int k;
        if (reset) begin
            acc.delete();
            expWe   = 1'b0;
            expAddr = '0;
            expData = '0;
        end else begin
            expWe = 1'b0;
            if (isDone() || isError()) begin
                if (bus.rearm) acc.delete();
            end else if (bus.rx_valid) begin
                acc.push_back(bus.rx_data);
                if (acc.size() >= 8 && acc.size() % 4 == 0) begin
                    k       = (acc.size() - 8) / 4;
                    expWe   = 1'b1;
                    expAddr = AW'(k * 4);
                    expData = {acc[4 + 4 * k], acc[5 + 4 * k], acc[6 + 4 * k], acc[7 + 4 * k]};
                end
            end
        end
    end

    always @(negedge clk) begin
        wrRec_t rec;
        checkOutput("mem_we", bus.mem_we, expWe);
        if (expWe) begin
            checkOutput("mem_addr", bus.mem_addr, expAddr);
            checkOutput("mem_wdata", bus.mem_wdata, expData);
        end
        checkOutput("words_written", bus.words_written, wordsDone());
        checkOutput("busy", bus.busy, !(isDone() || isError()));
        checkOutput("done", bus.done, isDone());
        checkOutput("error", bus.error, isError());
        if (bus.mem_we === 1'b1) begin
            rec.cyc          = cycle;
            rec.addr         = bus.mem_addr;
            rec.data         = bus.mem_wdata;
            rec.doneAtStrobe = bus.done;
            writeLog.push_back(rec);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic queueWord(input logic [31:0] w);
        stim.push_back(w[31:24]);
        stim.push_back(w[23:16]);
        stim.push_back(w[15:8]);
        stim.push_back(w[7:0]);
    endtask

    task automatic applyStimulus(input int maxGap, input bit randRearm);
        for (int i = 0; i < stim.size(); i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = stim[i];
            bus.rearm    = randRearm && ($urandom_range(0, 7) == 0);
            tick();
            bus.rx_valid = 1'b0;
            bus.rearm    = 1'b0;
            if (maxGap > 0) repeat ($urandom_range(0, maxGap)) tick();
        end
        stim.delete();
    endtask

    task automatic pulseRearm();
        bus.rearm = 1'b1;
        tick();
        bus.rearm = 1'b0;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic checkWrite(input string name, input int idx, input logic [31:0] addr, input logic [31:0] data);
        if (writeLog.size() > idx) begin
            checkOutput({name, "_addr"}, writeLog[idx].addr, addr);
            checkOutput({name, "_data"}, writeLog[idx].data, data);
        end else begin
            checkOutput({name, "_present"}, writeLog.size(), idx + 1);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] words[3];
        logic [31:0] n;
        int          sel;
        int          cut;

        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        bus.rearm    = 1'b0;
        reset        = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        checkOutput("reset_busy", bus.busy, 1);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_error", bus.error, 0);
        checkOutput("reset_ww", bus.words_written, 0);
        checkOutput("reset_addr", bus.mem_addr, 0);
        checkOutput("reset_wdata", bus.mem_wdata, 0);

        // Two-word image, back to back.
        writeLog.delete();
        queueWord(32'd2);
        queueWord(32'h12345678);
        queueWord(32'h9ABCDEF0);
        applyStimulus(0, 1'b0);
        tick();
        checkOutput("t1_count", writeLog.size(), 2);
        checkWrite("t1_w0", 0, 32'h0, 32'h12345678);
        checkWrite("t1_w1", 1, 32'h4, 32'h9ABCDEF0);
        if (writeLog.size() == 2) begin
            checkOutput("t1_spacing", writeLog[1].cyc - writeLog[0].cyc, 4);
            checkOutput("t1_done_at_strobe", writeLog[1].doneAtStrobe, 1);
        end
        checkOutput("t1_done", bus.done, 1);
        checkOutput("t1_ww", bus.words_written, 2);

        // Empty image finishes one cycle after the header.
        pulseRearm();
        writeLog.delete();
        queueWord(32'd0);
        applyStimulus(0, 1'b0);
        checkOutput("t2_done", bus.done, 1);
        repeat (3) tick();
        checkOutput("t2_nowrite", writeLog.size(), 0);

        // Oversize header goes to ERROR and swallows the following bytes.
        pulseRearm();
        writeLog.delete();
        queueWord(32'h00010000);
        applyStimulus(0, 1'b0);
        checkOutput("t3_error", bus.error, 1);
        checkOutput("t3_busy", bus.busy, 0);
        queueWord(32'hAABBCCDD);
        applyStimulus(1, 1'b0);
        repeat (2) tick();
        checkOutput("t3_nowrite", writeLog.size(), 0);

        // A reset discards a partial word.
        pulseRearm();
        writeLog.delete();
        queueWord(32'd1);
        stim.push_back(8'h11);
        stim.push_back(8'h22);
        applyStimulus(3, 1'b0);
        pulseReset();
        queueWord(32'd1);
        queueWord(32'hCAFEBABE);
        applyStimulus(2, 1'b0);
        repeat (2) tick();
        checkOutput("t4_count", writeLog.size(), 1);
        checkWrite("t4_w0", 0, 32'h0, 32'hCAFEBABE);
        checkOutput("t4_done", bus.done, 1);

        // Bytes in DONE are dropped; rearm starts a fresh load.
        writeLog.delete();
        queueWord(32'hDEADBEEF);
        applyStimulus(0, 1'b0);
        repeat (2) tick();
        checkOutput("t5_nowrite", writeLog.size(), 0);
        checkOutput("t5_ww_hold", bus.words_written, 1);
        pulseRearm();
        checkOutput("t5_ww_clear", bus.words_written, 0);
        checkOutput("t5_busy", bus.busy, 1);
        queueWord(32'd1);
        queueWord(32'h01020304);
        applyStimulus(1, 1'b0);
        repeat (2) tick();
        checkWrite("t5_w0", 0, 32'h0, 32'h01020304);
        checkOutput("t5_ww", bus.words_written, 1);

        // Sixteen bytes on consecutive cycles.
        pulseRearm();
        writeLog.delete();
        queueWord(32'd3);
        for (int i = 0; i < 3; i++) begin
            words[i] = $urandom;
            queueWord(words[i]);
        end
        applyStimulus(0, 1'b0);
        repeat (2) tick();
        checkOutput("t6_count", writeLog.size(), 3);
        for (int i = 0; i < 3; i++) begin
            checkWrite($sformatf("t6_w%0d", i), i, 32'(i * 4), words[i]);
        end
        if (writeLog.size() == 3) begin
            checkOutput("t6_gap01", writeLog[1].cyc - writeLog[0].cyc, 4);
            checkOutput("t6_gap12", writeLog[2].cyc - writeLog[1].cyc, 4);
        end

        // Simultaneous byte and rearm in DONE: byte dropped, rearm wins.
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
        bus.rearm    = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        bus.rearm    = 1'b0;
        checkOutput("t7_rearmed", bus.busy, 1);

        // Randomised loads checked cycle by cycle against the model.
        for (int t = 0; t < 25; t++) begin
            pulseRearm();
            sel = $urandom_range(0, 9);
            if (sel == 0)      n = 32'd0;
            else if (sel == 1) n = 32'(MAXW) + 32'd1 + 32'($urandom_range(0, 100000));
            else if (sel == 2) n = $urandom | 32'h8000_0000;
            else               n = 32'($urandom_range(1, 6));
            queueWord(n);
            if (n >= 1 && n <= 6) begin
                for (int w = 0; w < int'(n); w++) queueWord($urandom);
            end else begin
                repeat ($urandom_range(0, 5)) stim.push_back(8'($urandom));
            end
            if ($urandom_range(0, 7) == 0) begin
                cut = $urandom_range(1, stim.size() - 1);
                while (stim.size() > cut) void'(stim.pop_back());
                applyStimulus($urandom_range(0, 2), 1'b1);
                pulseReset();
            end else begin
                applyStimulus($urandom_range(0, 2), 1'b1);
                if ($urandom_range(0, 3) == 0) begin
                    bus.rx_valid = 1'b1;
                    bus.rx_data  = 8'($urandom);
                    bus.rearm    = 1'b1;
                    tick();
                    bus.rx_valid = 1'b0;
                    bus.rearm    = 1'b0;
                end
            end
            repeat (2) tick();
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction memory: receives the program image as a byte stream from the UART receiver and writes it into instruction RAM as 32-bit words.
- The CPU fetch path reads the same memory with byte addresses whose low two bits are dropped.
- Sits between the UART RX byte interface and the instruction-memory write port; holds the core off until loading completes.

Parameters:
- ADDR_WIDTH, 17, byte-address width of instruction memory (matches `ROM_ADDRESS_BITWIDTH`).
- MAX_WORDS, 2**(ADDR_WIDTH-2), capacity in 32-bit words; header counts above this are rejected.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- rx_valid  input  1  one-cycle strobe: rx_data holds a new byte. No back-pressure exists; every strobe must be consumed.
- rx_data  input  8  received byte.
- rearm  input  1  one-cycle pulse: return from DONE/ERROR to HEADER for a new load.
- mem_we  output  1  one-cycle write strobe to instruction memory.
- mem_addr  output  ADDR_WIDTH  byte address of the write; low 2 bits always 0.
- mem_wdata  output  32  word to write.
- words_written  output  ADDR_WIDTH-1  count of words written in the current load.
- busy  output  1  high in HEADER and BODY states.
- done  output  1  level, high in DONE state.
- error  output  1  level, high in ERROR state.

Behaviour:
- Stream format: 4-byte word count N, big-endian, followed by N words, each big-endian. The first byte of a word goes to bits 31:24.
- Reset (async, active-high): state=HEADER; byte_cnt=0; shift register=0; N=0; mem_we=0; mem_addr=0; mem_wdata=0; words_written=0; busy=1; done=0; error=0. A partial word or header in progress is discarded.
- States: HEADER, BODY, DONE, ERROR.
- HEADER:
  - Each rx_valid shifts rx_data into a 32-bit shift register (shift left 8) and increments the 2-bit byte_cnt.
  - On the 4th byte (byte_cnt wraps 3->0), N is latched.
  - N==0 -> DONE. N>MAX_WORDS -> ERROR. Otherwise -> BODY.
- BODY:
  - Bytes are assembled in the same way.
  - On the 4th byte of a word, the next cycle has mem_we=1 for exactly one cycle, with mem_wdata = assembled word and mem_addr = {words_written, 2'b00}.
  - words_written increments in the same cycle as the write strobe.
  - When words_written reaches N on that increment -> DONE, in the same cycle the strobe is asserted.
- Latency: write strobe appears 1 cycle after the rx_valid carrying the 4th byte of the word. Back-to-back rx_valid every cycle is supported without byte loss.
- DONE / ERROR:
  - rx_valid is ignored; no writes occur.
  - rearm -> HEADER, clearing byte_cnt, N and words_written. mem_addr and mem_wdata keep their last values.
  - rearm in HEADER or BODY is ignored.
- mem_addr and mem_wdata are registered and hold their values between strobes. They are only meaningful while mem_we=1.
- If rx_valid and rearm arrive together in DONE/ERROR, the byte is dropped and rearm takes effect.
- Width rules:
  - N is latched as 32 bits and compared against MAX_WORDS at full width.
  - Upper header bits set -> ERROR; no truncation.
  - words_written never exceeds N, and addresses never wrap.

Decomposition:
- Shared package (`define.sv`): loader state enum {HEADER, BODY, DONE, ERROR} and the header byte-count constant (4).
- One natural sub-module, `byte_assembler`: collects 4 bytes into a big-endian word and emits a word_valid pulse. It is reused for both the header and body phases.
- FSM, counters and the write port stay in program_loader.

Test Plan:
- Header 00 00 00 02, then bytes 12 34 56 78 9A BC DE F0 on consecutive cycles -> two strobes: addr 0x0 data 0x12345678, then addr 0x4 data 0x9ABCDEF0. done=1 the cycle of the 2nd strobe; words_written=2.
- Header 00 00 00 00 -> done=1 one cycle after the 4th byte; mem_we never asserted.
- Header 00 01 00 00 with ADDR_WIDTH=17 (N=65536 > MAX_WORDS=32768) -> error=1, busy=0. Subsequent bytes AA BB CC DD produce no writes.
- Header N=1, bytes 11 22 sent with idle gaps, reset pulsed, then header N=1 and word CA FE BA BE -> single write addr 0x0 data 0xCAFEBABE; the partial bytes 11 22 never appear.
- In DONE after N=1, send DE AD BE EF -> no writes. Pulse rearm, then header N=1 and word 01 02 03 04 -> write addr 0x0 data 0x01020304; words_written restarts at 0.
- rx_valid high every cycle for the header plus 3 words (16 bytes) -> exactly 3 strobes, each 4 cycles apart, at addresses 0x0, 0x4, 0x8, with no dropped bytes.
